multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multi-cycle control FSM for the sequential RV64I core. It sequences one instruction at a time through fetch, decode, execute, memory, writeback and PC update, time-sharing the single 64-bit ALU between instruction execution and PC arithmetic. It drives the ALU's 32-bit instruction input, the operand-select muxes, the register-file, PC and IR write strobes, and the instruction and data memory request handshakes. It halts on illegal instructions or on a memory that stops responding.

## Interface
- CNT_W, 32: width of the retired-instruction counter.
- TIMEOUT, 16: maximum number of wait cycles on a memory request. 0 disables the timeout.
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ir  in  32  current instruction register contents (opcode [6:0], funct3 [14:12]).
- imem_req  out  1  instruction fetch request.
- imem_ready  in  1  fetch data valid; sampled in the same cycle.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- dmem_ready  in  1  data access complete; sampled in the same cycle.
- alu_zero  in  1  ALU `zero` output.
- alu_instr  out  32  instruction word driven to the ALU.
- alu_a_sel  out  1  ALU operand A: 0 = rs1, 1 = PC.
- alu_b_sel  out  2  ALU operand B: 0 = rs2, 1 = imm, 2 = constant 4.
- ir_we, reg_we, pc_we  out  1 each  write strobes.
- wb_sel  out  1  register writeback source: 0 = ALU, 1 = load data.
- state  out  3  current FSM state.
- halt  out  1  sticky trap indication.
- err_code  out  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout.
- retired  out  CNT_W  count of completed instructions.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, PCUPD=5, TRAP=7. Outputs are Moore, decoded from state plus the latched type and taken flags.
- Supported opcodes:
  - 0110011 (R)
  - 0010011 (I-ALU)
  - 0000011 (load)
  - 0100011 (store)
  - 1100011 with funct3 0 or 1 only (BEQ/BNE)
- Any other opcode, or a branch with any other funct3, goes to TRAP with err_code=1.
- FETCH: imem_req=1. When imem_ready=1, ir_we=1 and next state is DECODE.
- DECODE: classifies the IR and latches the instruction type. Next state is EXEC, or TRAP if illegal.
- EXEC: alu_instr = ir.
  - R: a_sel=0, b_sel=0, next WB.
  - I-ALU: a_sel=0, b_sel=1, next WB.
  - load/store: a_sel=0, b_sel=1, next MEM. The ALU adds by opcode.
  - branch: a_sel=0, b_sel=0. Latch taken = alu_zero XOR funct3[0]; next PCUPD.
- MEM: dmem_req=1, dmem_we=1 for a store. On dmem_ready, a load goes to WB and a store goes to PCUPD. The ALU selects of EXEC are held.
- WB: reg_we=1, wb_sel=1 for a load, else 0. ALU selects of EXEC are held. Next PCUPD.
- PCUPD: alu_instr=32'h0000_0033 (ADD), a_sel=1, b_sel = 1 if taken, else 2. pc_we=1 and retired increments. Next FETCH. The taken flag clears.
- TRAP: all strobes and requests are 0, halt=1. The FSM stays in TRAP until reset.
- Strobes are 0 in every state not listed above. alu_instr is 0 in FETCH, DECODE and TRAP.
- Timeout: wait_cnt clears on entry to FETCH or MEM and increments each cycle the request is pending without ready.
  - If ready=1 in the same cycle that wait_cnt reaches TIMEOUT, ready wins.
  - Otherwise, when wait_cnt == TIMEOUT and ready=0, go to TRAP with err_code 2 (FETCH) or 3 (MEM).
- imem_ready outside FETCH and dmem_ready outside MEM are ignored.
- retired wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n low, asynchronous):
  - state=FETCH, halt=0, err_code=0, retired=0, wait_cnt=0, taken=0.
  - All strobes and requests are forced to 0 while rst_n is low. imem_req rises in the first cycle after deassertion.
- Reset during a memory wait drops the request immediately. Memories must tolerate an abandoned request.
- Cycles per instruction, zero-wait memory:
  - R / I-ALU: 5
  - load: 6
  - store: 5
  - branch: 4
- Each memory wait cycle adds 1.
- retired updates on the clock edge that leaves PCUPD, and is visible in the next FETCH.
- Only one of ir_we, reg_we, pc_we is high in any cycle.

## Test plan
- Reset release, ir=0x00208133 (add), imem_ready and dmem_ready tied high -> state sequence 0,1,2,4,5,0; reg_we high in cycle 3; pc_we in cycle 4 with b_sel=2; retired=1.
- Load, ir opcode 0000011, dmem_ready delayed 3 cycles -> MEM lasts 4 cycles; dmem_we=0; wb_sel=1 in WB; 9 cycles total.
- BEQ (ir=0x00208463) with alu_zero=1 -> PCUPD shows alu_instr=0x33, a_sel=1, b_sel=1; with alu_zero=0, b_sel=2. BNE gives the inverse.
- ir opcode 1111111 -> TRAP after DECODE; halt=1, err_code=1; stays in TRAP for 100 cycles with imem_ready high.
- TIMEOUT=16, imem_ready held low -> TRAP with err_code=2 after 17 FETCH cycles. With ready arriving on the 17th cycle instead, the instruction proceeds to DECODE.
- rst_n pulsed low mid-MEM of a store -> dmem_req drops asynchronously; state=0, retired=0; normal fetch resumes after release.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: controller-to-datapath/memory bundle; master = controller, slave = datapath and memories
interface multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0] ir;
  logic imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, alu_zero;
  logic [31:0] alu_instr;
  logic alu_a_sel;
  logic [1:0] alu_b_sel;
  logic ir_we, reg_we, pc_we, wb_sel;
  logic [2:0] state;
  logic halt;
  logic [1:0] err_code;
  logic [CNT_W-1:0] retired;
  modport master (
    input ir, imem_ready, dmem_ready, alu_zero,
    output imem_req, dmem_req, dmem_we, alu_instr, alu_a_sel, alu_b_sel,
    output ir_we, reg_we, pc_we, wb_sel, state, halt, err_code, retired
  );
  modport slave (
    output ir, imem_ready, dmem_ready, alu_zero,
    input imem_req, dmem_req, dmem_we, alu_instr, alu_a_sel, alu_b_sel,
    input ir_we, reg_we, pc_we, wb_sel, state, halt, err_code, retired
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV64I multi-cycle control FSM; ports clk, rst_n (async low) and bus (ir/ready/alu_zero in, strobes/selects/requests/status out)
module multicycle_ctrl #(
  parameter int CNT_W = 32,
  parameter int TIMEOUT = 16
) (
  input logic clk,
  input logic rst_n,
  multicycle_ctrl_if.master bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, PCUPD = 3'd5, TRAP = 3'd7} state_t;
  typedef enum logic [2:0] {T_R, T_I, T_LD, T_ST, T_BR} typ_t;
  localparam int WW = $clog2(TIMEOUT + 2);
  state_t state_q, state_d;
  typ_t typ_q, typ_d, dec;
  logic taken_q, taken_d;
  logic [1:0] err_q, err_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [6:0] op;
  logic illegal, tmo, exu;
  assign op = bus.ir[6:0];
  assign dec = op == 7'b0110011 ? T_R : op == 7'b0010011 ? T_I : op == 7'b0000011 ? T_LD :
               op == 7'b0100011 ? T_ST : T_BR;
  // only BEQ/BNE are supported branches: funct3 must be 000 or 001
  assign illegal = !(op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011}) ||
                   (op == 7'b1100011 && bus.ir[14:13] != 2'b00);
  assign tmo = (TIMEOUT != 0) && (wait_q == WW'(TIMEOUT));
  assign exu = state_q inside {EXEC, MEM, WB};
  always_comb begin
    state_d = state_q;
    typ_d = typ_q;
    taken_d = taken_q;
    err_d = err_q;
    wait_d = wait_q;
    ret_d = ret_q;
    case (state_q)
      FETCH: begin
        // ready beats a timeout reached in the same cycle
        if (bus.imem_ready) state_d = DECODE;
        else if (tmo) begin
          state_d = TRAP;
          err_d = 2'd2;
        end else wait_d = wait_q + WW'(1);
      end
      DECODE: begin
        typ_d = dec;
        state_d = illegal ? TRAP : EXEC;
        err_d = illegal ? 2'd1 : err_q;
      end
      EXEC: begin
        taken_d = typ_q == T_BR && (bus.alu_zero ^ bus.ir[12]);
        state_d = typ_q inside {T_LD, T_ST} ? MEM : typ_q == T_BR ? PCUPD : WB;
        wait_d = '0;
      end
      MEM: begin
        if (bus.dmem_ready) state_d = typ_q == T_LD ? WB : PCUPD;
        else if (tmo) begin
          state_d = TRAP;
          err_d = 2'd3;
        end else wait_d = wait_q + WW'(1);
      end
      WB: state_d = PCUPD;
      PCUPD: begin
        state_d = FETCH;
        taken_d = 1'b0;
        ret_d = ret_q + CNT_W'(1);
        wait_d = '0;
      end
      default: state_d = TRAP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      typ_q <= T_R;
      taken_q <= 1'b0;
      err_q <= 2'd0;
      wait_q <= '0;
      ret_q <= '0;
    end else begin
      state_q <= state_d;
      typ_q <= typ_d;
      taken_q <= taken_d;
      err_q <= err_d;
      wait_q <= wait_d;
      ret_q <= ret_d;
    end
  end
  // strobes and requests are gated by rst_n so they drop the moment reset asserts
  always_comb begin
    bus.imem_req = rst_n && state_q == FETCH;
    bus.ir_we = rst_n && state_q == FETCH && bus.imem_ready;
    bus.dmem_req = rst_n && state_q == MEM;
    bus.dmem_we = rst_n && state_q == MEM && typ_q == T_ST;
    bus.reg_we = rst_n && state_q == WB;
    bus.pc_we = rst_n && state_q == PCUPD;
    bus.wb_sel = state_q == WB && typ_q == T_LD;
    bus.alu_instr = exu ? bus.ir : state_q == PCUPD ? 32'h0000_0033 : 32'h0;
    bus.alu_a_sel = state_q == PCUPD;
    bus.alu_b_sel = state_q == PCUPD ? (taken_q ? 2'd1 : 2'd2) :
                    (exu && typ_q inside {T_I, T_LD, T_ST}) ? 2'd1 : 2'd0;
    bus.state = state_q;
    bus.halt = state_q == TRAP;
    bus.err_code = err_q;
    bus.retired = ret_q;
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed and randomized instruction traces checked against a phase-schedule model
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int ret_m = 0;
  always #5 clk = ~clk;
  multicycle_ctrl_if #(.CNT_W(32)) bus();
  multicycle_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // instruction class: 0 R, 1 I-ALU, 2 load, 3 store, 4 branch, 5 illegal
  function automatic int cls(input logic [31:0] i);
    case (i[6:0])
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0000011: return 2;
      7'b0100011: return 3;
      7'b1100011: return (i[14:12] <= 3'd1) ? 4 : 5;
      default: return 5;
    endcase
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 4);
    r[6:0] = k == 0 ? 7'b0110011 : k == 1 ? 7'b0010011 : k == 2 ? 7'b0000011 :
             k == 3 ? 7'b0100011 : 7'b1100011;
    if (k == 4) r[14:12] = {2'b00, r[12]};
    return r;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_halt", bus.halt, 0);
    chk("rst_err", bus.err_code, 0);
    chk("rst_retired", bus.retired, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ret_m = 0;
  endtask

  // Builds the expected phase schedule (FETCH waits fw, MEM waits mw) and checks every cycle.
  task automatic run_instr(input logic [31:0] instr, input int fw, input int mw, input bit z, input int trap_hold);
    int c = cls(instr);
    int q[$];
    int code = 0;
    bit tk = (c == 4) && (z ^ instr[12]);
    for (int k = 0; k <= fw && k < 17; k++) q.push_back(0);
    if (fw > 16) code = 2;
    else begin
      q.push_back(1);
      if (c == 5) code = 1;
      else begin
        q.push_back(2);
        if (c == 2 || c == 3) begin
          for (int k = 0; k <= mw && k < 17; k++) q.push_back(3);
          if (mw > 16) code = 3;
        end
        if (code == 0) begin
          if (c < 3) q.push_back(4);
          q.push_back(5);
        end
      end
    end
    if (code != 0) repeat (trap_hold) q.push_back(7);
    bus.ir = instr;
    bus.alu_zero = z;
    for (int k = 0; k < q.size(); k++) begin
      int p = q[k];
      int nx = (k + 1 < q.size()) ? q[k + 1] : 0;
      bit last_f = p == 0 && nx == 1;
      bit last_m = p == 3 && (nx == 4 || nx == 5);
      bit ex = p == 2 || p == 3 || p == 4;
      bus.imem_ready = p == 0 ? last_f : 1'($urandom_range(0, 1));
      bus.dmem_ready = p == 3 ? last_m : 1'($urandom_range(0, 1));
      #1;
      chk("state", bus.state, p);
      chk("imem_req", bus.imem_req, p == 0);
      chk("ir_we", bus.ir_we, last_f);
      chk("dmem_req", bus.dmem_req, p == 3);
      chk("dmem_we", bus.dmem_we, p == 3 && c == 3);
      chk("reg_we", bus.reg_we, p == 4);
      chk("wb_sel", bus.wb_sel, p == 4 && c == 2);
      chk("pc_we", bus.pc_we, p == 5);
      chk("alu_instr", bus.alu_instr, ex ? instr : p == 5 ? 32'h33 : 32'h0);
      chk("a_sel", bus.alu_a_sel, p == 5);
      chk("b_sel", bus.alu_b_sel, p == 5 ? (tk ? 1 : 2) : (ex && c >= 1 && c <= 3) ? 1 : 0);
      chk("halt", bus.halt, p == 7);
      chk("err_code", bus.err_code, p == 7 ? code : 0);
      chk("retired", bus.retired, ret_m);
      @(posedge clk);
      #1;
      if (p == 5) ret_m++;
    end
  endtask

  initial begin
    bus.ir = 32'h0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.alu_zero = 1'b0;
    #2;
    do_reset();
    run_instr(32'h0020_8133, 0, 0, 1'b0, 0);
    chk("retired_after_add", bus.retired, 1);
    run_instr(32'h0000_3083, 0, 3, 1'b0, 0);
    run_instr(32'h0020_8463, 0, 0, 1'b1, 0);
    run_instr(32'h0020_8463, 0, 0, 1'b0, 0);
    run_instr(32'h0020_9463, 0, 0, 1'b1, 0);
    run_instr(32'h0020_9463, 0, 0, 1'b0, 0);
    run_instr(32'h0011_3023, 1, 2, 1'b0, 0);
    run_instr(32'h0020_8133, 16, 0, 1'b0, 0);
    run_instr(32'h0000_3083, 0, 16, 1'b0, 0);
    for (int n = 0; n < 40; n++)
      run_instr(rnd_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), 0);
    run_instr(32'h0000_007F, 0, 0, 1'b0, 100);
    do_reset();
    run_instr(32'h0020_A463, 0, 0, 1'b0, 3);
    do_reset();
    run_instr(32'h0020_8133, 17, 0, 1'b0, 5);
    do_reset();
    run_instr(32'h0011_3023, 0, 17, 1'b0, 3);
    do_reset();
    run_instr(32'h0020_8133, 0, 0, 1'b0, 0);
    bus.ir = 32'h0011_3023;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("mem_state", bus.state, 3);
    chk("mem_dmem_req", bus.dmem_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_dmem_req", bus.dmem_req, 0);
    chk("async_state", bus.state, 0);
    chk("async_retired", bus.retired, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ret_m = 0;
    run_instr(32'h0011_3023, 0, 0, 1'b0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
